// File: rtl/net_packet_rx.sv
// Core-side receiver for the boot/control net packet stream: buffers packets in a FIFO and
// dispatches them as imem / register / barrier / PC write strobes. Optional counters: NET_RX_STATS_EN.
module net_packet_rx #(
  parameter int         FIFO_DEPTH_P = 4,
  parameter logic [9:0] MY_ID_P      = 10'd1,
  parameter int         IMEM_AW_P    = 10,
  parameter int         RF_AW_P      = 6,
  parameter int         MASK_W_P     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [9:0]           pkt_id_i,
  input  logic [2:0]           pkt_op_i,
  input  logic [31:0]          pkt_data_i,
  input  logic [9:0]           pkt_addr_i,
  output logic                 imem_wen_o,
  output logic [IMEM_AW_P-1:0] imem_addr_o,
  output logic [15:0]          imem_data_o,
  input  logic                 imem_ready_i,
  output logic                 rf_wen_o,
  output logic [RF_AW_P-1:0]   rf_addr_o,
  output logic [31:0]          rf_data_o,
  output logic                 bar_wen_o,
  output logic [MASK_W_P-1:0]  bar_mask_o,
  output logic                 pc_wen_o,
  output logic [IMEM_AW_P-1:0] pc_o,
  output logic                 run_o,
  output logic                 err_o
`ifdef NET_RX_STATS_EN
  ,
  output logic [15:0]          stat_instr_o,
  output logic [15:0]          stat_reg_o,
  output logic [15:0]          stat_drop_o
`endif
);

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;
  localparam int         PTR_W    = $clog2(FIFO_DEPTH_P);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef struct packed {
    logic [2:0]  op;
    logic [9:0]  addr;
    logic [31:0] data;
  } pkt_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_IMEM} state_t;

  pkt_t         r_mem [FIFO_DEPTH_P];
  logic [PTR_W:0] r_wrPtr, r_rdPtr;
  pkt_t         r_cur;
  state_t       r_state;

  logic w_full, w_empty, w_accept, w_push, w_pop, w_stageFree, w_issue;
  pkt_t w_head;

  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_full      = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                       (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign pkt_ready_o = reset && !w_full;
  assign w_accept    = pkt_valid_i && pkt_ready_o;
  assign w_push      = w_accept && (pkt_id_i == MY_ID_P) && (pkt_op_i != OP_NULL);
  // The output stage is busy only while an imem write is waiting for imem_ready_i.
  assign w_stageFree = !imem_wen_o || imem_ready_i;
  assign w_issue     = (r_state != IDLE) && w_stageFree;
  assign w_pop       = !w_empty && ((r_state == IDLE) || w_issue);
  assign w_head      = r_mem[r_rdPtr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr[PTR_W-1:0]] <= '{op: pkt_op_i, addr: pkt_addr_i, data: pkt_data_i};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      imem_wen_o  <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      rf_wen_o    <= 1'b0;
      rf_addr_o   <= '0;
      rf_data_o   <= '0;
      bar_wen_o   <= 1'b0;
      bar_mask_o  <= '0;
      pc_wen_o    <= 1'b0;
      pc_o        <= '0;
      run_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      rf_wen_o  <= 1'b0;
      bar_wen_o <= 1'b0;
      pc_wen_o  <= 1'b0;
      if (imem_wen_o && imem_ready_i) imem_wen_o <= 1'b0;
      if (w_pop) r_cur <= w_head;
      case (r_state)
        IDLE: if (!w_empty) r_state <= ISSUE;
        ISSUE, WAIT_IMEM: begin
          if (!w_stageFree) begin
            r_state <= WAIT_IMEM;
          end else begin
            case (r_cur.op)
              OP_INSTR: begin
                imem_wen_o  <= 1'b1;
                imem_addr_o <= r_cur.addr[IMEM_AW_P-1:0];
                imem_data_o <= r_cur.data[15:0];
              end
              OP_REG: begin
                rf_wen_o  <= 1'b1;
                rf_addr_o <= r_cur.addr[RF_AW_P-1:0];
                rf_data_o <= r_cur.data;
              end
              OP_BAR: begin
                bar_wen_o  <= 1'b1;
                bar_mask_o <= r_cur.data[MASK_W_P-1:0];
              end
              OP_PC: begin
                pc_wen_o <= 1'b1;
                pc_o     <= r_cur.addr[IMEM_AW_P-1:0];
                run_o    <= 1'b1;
              end
              default: err_o <= 1'b1;
            endcase
            r_state <= w_empty ? IDLE : ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef NET_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_instr_o <= '0;
      stat_reg_o   <= '0;
      stat_drop_o  <= '0;
    end else begin
      if (w_issue && (r_cur.op == OP_INSTR) && (stat_instr_o != 16'hFFFF))
        stat_instr_o <= stat_instr_o + 16'd1;
      if (w_issue && (r_cur.op == OP_REG) && (stat_reg_o != 16'hFFFF))
        stat_reg_o <= stat_reg_o + 16'd1;
      if (w_accept && (pkt_id_i != MY_ID_P) && (stat_drop_o != 16'hFFFF))
        stat_drop_o <= stat_drop_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_net_packet_rx.sv
// Directed self-checking bench for net_packet_rx; a negedge monitor logs every completed
// write strobe and each test compares that log against hand-derived expected events.
module tb_net_packet_rx;

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid_i, pkt_ready_o;
  logic [9:0]  pkt_id_i, pkt_addr_i;
  logic [2:0]  pkt_op_i;
  logic [31:0] pkt_data_i;
  logic        imem_wen_o, imem_ready_i;
  logic [9:0]  imem_addr_o;
  logic [15:0] imem_data_o;
  logic        rf_wen_o;
  logic [5:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        bar_wen_o;
  logic [2:0]  bar_mask_o;
  logic        pc_wen_o;
  logic [9:0]  pc_o;
  logic        run_o, err_o;
`ifdef NET_RX_STATS_EN
  logic [15:0] stat_instr_o, stat_reg_o, stat_drop_o;
`endif

  net_packet_rx dut (
    .clk(clk), .reset(reset),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_id_i(pkt_id_i), .pkt_op_i(pkt_op_i), .pkt_data_i(pkt_data_i), .pkt_addr_i(pkt_addr_i),
    .imem_wen_o(imem_wen_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .imem_ready_i(imem_ready_i),
    .rf_wen_o(rf_wen_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .bar_wen_o(bar_wen_o), .bar_mask_o(bar_mask_o),
    .pc_wen_o(pc_wen_o), .pc_o(pc_o), .run_o(run_o), .err_o(err_o)
`ifdef NET_RX_STATS_EN
    , .stat_instr_o(stat_instr_o), .stat_reg_o(stat_reg_o), .stat_drop_o(stat_drop_o)
`endif
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;
  int cyc = 0;
  int acceptCyc = 0;
  int firstAccept = 0;
  logic [63:0] obsLog[$];
  int          obsCyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mkEv(input logic [3:0] k, input logic [9:0] a, input logic [31:0] d);
    return {k, 18'd0, a, d};
  endfunction

  // Log one event per completed write: imem needs wen and ready together, the rest are pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_wen_o && imem_ready_i) begin
        obsLog.push_back(mkEv(4'd1, imem_addr_o, {16'd0, imem_data_o}));
        obsCyc.push_back(cyc);
      end
      if (rf_wen_o) begin
        obsLog.push_back(mkEv(4'd2, {4'd0, rf_addr_o}, rf_data_o));
        obsCyc.push_back(cyc);
      end
      if (bar_wen_o) begin
        obsLog.push_back(mkEv(4'd3, 10'd0, {29'd0, bar_mask_o}));
        obsCyc.push_back(cyc);
      end
      if (pc_wen_o) begin
        obsLog.push_back(mkEv(4'd4, pc_o, 32'd0));
        obsCyc.push_back(cyc);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one packet starting at posedge+1 and return just after the edge that accepts it.
  task automatic applyStimulus(input logic [9:0] id, input logic [2:0] op,
                               input logic [9:0] addr, input logic [31:0] data);
    logic rdy;
    rdy = 1'b0;
    pkt_valid_i = 1'b1;
    pkt_id_i    = id;
    pkt_op_i    = op;
    pkt_addr_i  = addr;
    pkt_data_i  = data;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = pkt_ready_o;
      @(posedge clk);
      #1;
      if (rdy) begin
        acceptCyc = cyc;
        return;
      end
    end
    checkOutput("acceptTimeout", 64'(rdy), 64'd1);
    pkt_valid_i = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    pkt_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    obsLog.delete();
    obsCyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; pkt_valid_i = 1'b0; pkt_id_i = '0; pkt_op_i = '0;
    pkt_data_i = '0; pkt_addr_i = '0; imem_ready_i = 1'b1;

    // Reset for two edges, then release.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReady", 64'(pkt_ready_o), 64'd0);
    checkOutput("resetStrobes", 64'({imem_wen_o, rf_wen_o, bar_wen_o, pc_wen_o, run_o, err_o}), 64'd0);
    checkOutput("resetFields", {imem_addr_o, imem_data_o, rf_addr_o, bar_mask_o, pc_o, 19'd0}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("postResetReady", 64'(pkt_ready_o), 64'd1);
    checkOutput("postResetRfData", 64'(rf_data_o), 64'd0);
    @(posedge clk);
    #1;

    // REG, BAR, PC back-to-back; strobes two cycles after acceptance, one per cycle.
    applyStimulus(10'd1, OP_REG, 10'h3C5, 32'hDEADBEEF);
    applyStimulus(10'd1, OP_BAR, 10'h000, 32'h0000_0002);
    applyStimulus(10'd1, OP_PC,  10'h000, 32'h0000_0000);
    pkt_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("regStrobe", 64'({rf_wen_o, bar_wen_o, pc_wen_o, run_o}), 64'b1000);
    checkOutput("regWrite", {26'd0, rf_addr_o, rf_data_o}, {26'd0, 6'd5, 32'hDEADBEEF});
    @(negedge clk);
    checkOutput("barStrobe", 64'({rf_wen_o, bar_wen_o, pc_wen_o, run_o}), 64'b0100);
    checkOutput("barMask", 64'(bar_mask_o), 64'b010);
    @(negedge clk);
    checkOutput("pcStrobe", 64'({rf_wen_o, bar_wen_o, pc_wen_o, run_o}), 64'b0011);
    checkOutput("pcValue", 64'(pc_o), 64'd0);
    @(negedge clk);
    checkOutput("pcPulseEnd", 64'({rf_wen_o, bar_wen_o, pc_wen_o, run_o}), 64'b0001);
    checkOutput("rfDataHeld", 64'(rf_data_o), 64'hDEADBEEF);
    @(posedge clk);
    #1;

    // 1024 back-to-back INSTR packets with imem always ready (also live reprogramming after run).
    clearLog();
    imem_ready_i = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(10'd1, OP_INSTR, 10'(i), {16'hFFFF, 16'(i) ^ 16'hA5A5});
      if (i == 0) firstAccept = acceptCyc;
    end
    waitCycles(6);
    checkOutput("instrCount", 64'(obsLog.size()), 64'd1024);
    for (int i = 0; i < 1024; i++) begin
      if (i < obsLog.size())
        checkOutput($sformatf("instr%0d", i), obsLog[i], mkEv(4'd1, 10'(i), {16'd0, 16'(i) ^ 16'hA5A5}));
    end
    if (obsLog.size() == 1024) begin
      checkOutput("instrLatency", 64'(obsCyc[0] - firstAccept), 64'd2);
      checkOutput("instrThroughput", 64'(obsCyc[1023] - obsCyc[0]), 64'd1023);
    end

    // imem stall: FIFO fills, ready drops, the head write is held, no loss after release.
    clearLog();
    imem_ready_i = 1'b0;
    for (int k = 0; k < 6; k++)
      applyStimulus(10'd1, OP_INSTR, 10'(100 + k), {16'hBEEF, 16'(16'h1000 + k)});
    pkt_valid_i = 1'b0;
    checkOutput("stallFullReady", 64'(pkt_ready_o), 64'd0);
    checkOutput("stallHead", 64'({imem_wen_o, imem_addr_o, imem_data_o}), 64'({1'b1, 10'd100, 16'h1000}));
    waitCycles(5);
    checkOutput("stallHold", 64'({imem_wen_o, imem_addr_o, imem_data_o}), 64'({1'b1, 10'd100, 16'h1000}));
    checkOutput("stallStillFull", 64'(pkt_ready_o), 64'd0);
    checkOutput("stallNoWrites", 64'(obsLog.size()), 64'd0);
    imem_ready_i = 1'b1;
    waitCycles(1);
    checkOutput("releaseReady", 64'(pkt_ready_o), 64'd1);
    waitCycles(8);
    checkOutput("stallCount", 64'(obsLog.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < obsLog.size())
        checkOutput($sformatf("stall%0d", k), obsLog[k], mkEv(4'd1, 10'(100 + k), {16'd0, 16'(16'h1000 + k)}));
    end

    // Foreign ID and NULL are swallowed; unknown op flags err; a second PC re-pulses.
    clearLog();
    applyStimulus(10'd2, OP_REG,  10'd7, 32'h0000_0055);
    applyStimulus(10'd1, OP_NULL, 10'd8, 32'h0000_0066);
    waitCycles(5);
    checkOutput("dropNoWrites", 64'(obsLog.size()), 64'd0);
    checkOutput("dropNoErr", 64'(err_o), 64'd0);
    checkOutput("dropRfHeld", 64'(rf_addr_o), 64'd5);
`ifdef NET_RX_STATS_EN
    checkOutput("statDrop", 64'(stat_drop_o), 64'd1);
    checkOutput("statInstr", 64'(stat_instr_o), 64'd1030);
    checkOutput("statReg", 64'(stat_reg_o), 64'd1);
`endif
    applyStimulus(10'd1, 3'd6, 10'd0, 32'd0);
    waitCycles(4);
    checkOutput("unknownErr", 64'(err_o), 64'd1);
    checkOutput("unknownNoWrites", 64'(obsLog.size()), 64'd0);
    applyStimulus(10'd1, OP_PC, 10'h2AB, 32'd0);
    waitCycles(4);
    checkOutput("pc2Count", 64'(obsLog.size()), 64'd1);
    if (obsLog.size() > 0) checkOutput("pc2Event", obsLog[0], mkEv(4'd4, 10'h2AB, 32'd0));
    checkOutput("pc2RunErr", 64'({run_o, err_o}), 64'b11);

    // Reset with packets buffered and imem stalled: everything clears, nothing replays.
    clearLog();
    imem_ready_i = 1'b0;
    for (int k = 0; k < 5; k++)
      applyStimulus(10'd1, OP_INSTR, 10'(200 + k), 32'(k));
    pkt_valid_i = 1'b0;
    checkOutput("preResetHeld", 64'({imem_wen_o, imem_addr_o}), 64'({1'b1, 10'd200}));
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midResetStrobes", 64'({imem_wen_o, rf_wen_o, bar_wen_o, pc_wen_o, run_o, err_o}), 64'd0);
    checkOutput("midResetReady", 64'(pkt_ready_o), 64'd0);
    checkOutput("midResetAddr", 64'({imem_addr_o, pc_o}), 64'd0);
    reset = 1'b1;
    imem_ready_i = 1'b1;
    waitCycles(8);
    checkOutput("noReplay", 64'(obsLog.size()), 64'd0);
    checkOutput("afterResetReady", 64'(pkt_ready_o), 64'd1);
    applyStimulus(10'd1, OP_REG, 10'd9, 32'hCAFEF00D);
    waitCycles(4);
    checkOutput("afterResetCount", 64'(obsLog.size()), 64'd1);
    if (obsLog.size() > 0) checkOutput("afterResetReg", obsLog[0], mkEv(4'd2, 10'd9, 32'hCAFEF00D));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
